qvga_pixel_streamer: RTL
========================

Name: qvga_pixel_streamer

Overview:
- Pixel-stream source that feeds the color detector and the VGA output.
- Generates 640x480@60 VGA timing on the pixel clock and reads the 320x240 RGB565 frame buffer.
- Drives DE, x_pixel, y_pixel and pixel_rgb_data with the camera image placed in the window x 0..319, y 240..479, the region the detector consumes.
- Compensates for frame-buffer read latency so that coordinates, syncs and pixel data leave the block aligned on the same cycle.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- IMG_X0, 0, image window left column
- IMG_Y0, 240, image window top line
- IMG_W, 320, image width
- IMG_H, 240, image height
- RD_LATENCY, 1, frame-buffer read latency in clk cycles (1..3)

Ports:
- clk  in  1  pixel clock (25 MHz), the only clock
- reset  in  1  asynchronous, active-high
- rd_en  out  1  frame-buffer read strobe
- rd_addr  out  17  frame-buffer word address, range 0..76799
- rd_data  in  16  RGB565 data, valid RD_LATENCY cycles after rd_en
- h_sync  out  1  horizontal sync, active low
- v_sync  out  1  vertical sync, active low
- DE  out  1  display enable, high in the 640x480 active area
- x_pixel  out  10  active-area column
- y_pixel  out  10  active-area line
- pixel_rgb_data  out  16  RGB565 pixel for (x_pixel, y_pixel)
- frame_start  out  1  one-cycle pulse with the output pixel (0,0)

Behaviour:
- Interface: single clock clk; reset is asynchronous and active-high.
- Stage 0 counters:
  - h_cnt runs 0..799 and wraps to 0.
  - v_cnt runs 0..524 and increments when h_cnt wraps; v_cnt wraps to 0 after 524.
- Window: in_win = (h_cnt in IMG_X0..IMG_X0+IMG_W-1) and (v_cnt in IMG_Y0..IMG_Y0+IMG_H-1).
- Read issue (registered, stage 1):
  - rd_en = in_win.
  - rd_addr holds a running address counter, not a multiplier.
  - The counter clears to 0 when stage 0 is at (IMG_X0, IMG_Y0).
  - It increments after each in-window issue and holds at all other times.
  - After address 76799 it holds until the next frame clears it.
- Output alignment: define L = 1 + RD_LATENCY.
  - h_sync, v_sync, DE, x_pixel, y_pixel, frame_start and in_win pass through an L-deep delay line.
  - The state of (h_cnt, v_cnt) therefore appears on the outputs exactly L cycles later.
  - It appears together with rd_data for that coordinate.
- Decode, all computed at stage 0 and then delayed:
  - DE = h_cnt<640 and v_cnt<480.
  - x_pixel = h_cnt and y_pixel = v_cnt when DE=1; both are 0 when DE=0.
  - h_sync = 0 for h_cnt 656..751.
  - v_sync = 0 for v_cnt 490..491.
  - frame_start = 1 when h_cnt=0 and v_cnt=0.
- Pixel data:
  - pixel_rgb_data = rd_data when the delayed in_win is 1.
  - pixel_rgb_data = 16'h0000 otherwise, including in-active-area pixels outside the window and all blanking.
- Reset values:
  - h_cnt = 0, v_cnt = 0, address counter = 0.
  - All delay-line stages: h_sync = 1, v_sync = 1, DE = 0, x_pixel = 0, y_pixel = 0, pixel_rgb_data = 0, frame_start = 0.
  - rd_en = 0, rd_addr = 0.
- Reset mid-frame: on release, the timing restarts at (0,0). Output frame_start pulses L cycles after the first post-reset cycle.
- No partial or garbage pixels are emitted: delay-line stages hold reset values until filled.
- Line and frame wrap in the same cycle (h=799, v=524) go to (0,0) with no dropped or duplicated line.
- All arithmetic is unsigned. Counter widths: h_cnt and v_cnt 10 bits, address counter 17 bits.

Optional Feature:
- Macro: QVGA_TEST_PATTERN_EN.
- With the macro defined:
  - Adds input pattern_sel [1:0].
  - 00 selects frame-buffer data.
  - 01, 10 and 11 replace the in-window data with solid red 16'hF800, green 16'h07E0 and blue 16'h001F respectively.
  - rd_en and rd_addr keep toggling normally.
  - pattern_sel is sampled at stage 0 and delayed with the pipeline.
  - Out-of-window pixels stay 0.
- Without the macro: the port is absent and in-window pixel data is always rd_data.

Test Plan:
- Reset release with a memory model where rd_data = addr[15:0] and RD_LATENCY=1:
  - First frame_start occurs 2 cycles after the first post-reset cycle.
  - At that cycle x_pixel=0, y_pixel=0, DE=1, pixel_rgb_data=0 (outside window).
- Timing:
  - h_sync is low for exactly 96 cycles per 800-cycle line.
  - v_sync is low for exactly 2 lines (1600 cycles) per 420000-cycle frame.
  - DE is high for 307200 cycles per frame.
- Window mapping:
  - Output (0,240) carries 16'h0000 (addr 0).
  - Output (319,240) carries 16'h013F.
  - Output (319,479) carries the low 16 bits of 76799 (16'h2BFF).
  - Output (320,240) carries 0 with DE=1.
  - rd_en count per frame is 76800.
- Latency sweep over RD_LATENCY = 1, 2, 3: the pixel at (5,250) equals the value at address 3205 in every case.
- Assert reset at (400,300) for 3 cycles:
  - Outputs return to reset values immediately.
  - After release, the next frame starts clean and rd_addr restarts at 0 at (0,240).
- With QVGA_TEST_PATTERN_EN and pattern_sel=01:
  - Every in-window pixel is 16'hF800; out-of-window pixels are 0.
  - Switching to 00 mid-frame takes effect L cycles later at the output.

Source files
------------

// File: rtl/qvga_pixel_streamer.sv
`timescale 1ns / 1ps
// VGA timing generator and QVGA frame-buffer reader whose syncs, coordinates and pixel data
// leave aligned after the read latency. Optional QVGA_TEST_PATTERN_EN adds pattern_sel overrides.
module qvga_pixel_streamer #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned IMG_X0     = 0,
    parameter int unsigned IMG_Y0     = 240,
    parameter int unsigned IMG_W      = 320,
    parameter int unsigned IMG_H      = 240,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
`ifdef QVGA_TEST_PATTERN_EN
    input  logic [1:0]  pattern_sel,
`endif
    output logic        rd_en,
    output logic [16:0] rd_addr,
    input  logic [15:0] rd_data,
    output logic        h_sync,
    output logic        v_sync,
    output logic        DE,
    output logic [9:0]  x_pixel,
    output logic [9:0]  y_pixel,
    output logic [15:0] pixel_rgb_data,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_FIRST  = H_ACTIVE + H_FP;
    localparam int unsigned HS_LAST   = HS_FIRST + H_SYNC - 1;
    localparam int unsigned VS_FIRST  = V_ACTIVE + V_FP;
    localparam int unsigned VS_LAST   = VS_FIRST + V_SYNC - 1;
    localparam int unsigned ADDR_LAST = IMG_W * IMG_H - 1;
    localparam int          PIPE_LEN  = 1 + int'(RD_LATENCY);

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
        logic       win;
`ifdef QVGA_TEST_PATTERN_EN
        logic [1:0] pat;
`endif
    } stage_t;

    function automatic stage_t stage_reset();
        stage_t s;
        s    = '0;
        s.hs = 1'b1;
        s.vs = 1'b1;
        return s;
    endfunction

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [16:0] addr_q, addr_d, addr_cur;
    logic        rd_en_q, rd_en_d;
    logic [16:0] rd_addr_q, rd_addr_d;
    logic        in_win, win_start;
    stage_t      stage0;
    stage_t      dl_q [PIPE_LEN];
    stage_t      out_s;

    // Stage 0 raster counters; line and frame wrap share the same cycle at (H_TOTAL-1, V_TOTAL-1).
    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == 10'(H_TOTAL - 1)) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == 10'(V_TOTAL - 1)) ? '0 : v_cnt_q + 10'd1;
        end
    end

    // Modular subtraction folds the lower and upper window bounds into one compare.
    assign in_win    = ((h_cnt_q - 10'(IMG_X0)) < 10'(IMG_W)) &&
                       ((v_cnt_q - 10'(IMG_Y0)) < 10'(IMG_H));
    assign win_start = (h_cnt_q == 10'(IMG_X0)) && (v_cnt_q == 10'(IMG_Y0));

    always_comb begin
        stage0     = stage_reset();
        stage0.de  = (h_cnt_q < 10'(H_ACTIVE)) && (v_cnt_q < 10'(V_ACTIVE));
        stage0.x   = stage0.de ? h_cnt_q : 10'd0;
        stage0.y   = stage0.de ? v_cnt_q : 10'd0;
        stage0.hs  = !((h_cnt_q >= 10'(HS_FIRST)) && (h_cnt_q <= 10'(HS_LAST)));
        stage0.vs  = !((v_cnt_q >= 10'(VS_FIRST)) && (v_cnt_q <= 10'(VS_LAST)));
        stage0.fs  = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        stage0.win = in_win;
`ifdef QVGA_TEST_PATTERN_EN
        stage0.pat = pattern_sel;
`endif
    end

    // Running read address: cleared at the window origin, saturates on the last image word.
    always_comb begin
        addr_cur  = win_start ? 17'd0 : addr_q;
        addr_d    = addr_cur;
        if (in_win && (addr_cur != 17'(ADDR_LAST))) begin
            addr_d = addr_cur + 17'd1;
        end
        rd_en_d   = in_win;
        rd_addr_d = addr_cur;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            addr_q    <= addr_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_LEN; i++) begin
                dl_q[i] <= stage_reset();
            end
        end else begin
            dl_q[0] <= stage0;
            for (int i = 1; i < PIPE_LEN; i++) begin
                dl_q[i] <= dl_q[i - 1];
            end
        end
    end

    assign out_s       = dl_q[PIPE_LEN - 1];
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign h_sync      = out_s.hs;
    assign v_sync      = out_s.vs;
    assign DE          = out_s.de;
    assign x_pixel     = out_s.x;
    assign y_pixel     = out_s.y;
    assign frame_start = out_s.fs;

    // rd_data arrives on the same cycle the delayed coordinate reaches the output.
    always_comb begin
        pixel_rgb_data = 16'h0000;
        if (out_s.win) begin
`ifdef QVGA_TEST_PATTERN_EN
            case (out_s.pat)
                2'b01:   pixel_rgb_data = 16'hF800;
                2'b10:   pixel_rgb_data = 16'h07E0;
                2'b11:   pixel_rgb_data = 16'h001F;
                default: pixel_rgb_data = rd_data;
            endcase
`else
            pixel_rgb_data = rd_data;
`endif
        end
    end

endmodule
